// File: rtl/sa_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array: loads W, streams
// skewed activation rows, deskews the bottom-row outputs and writes result rows.
module sa_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [AW:0]          i_m,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [AW-1:0]        o_wmem_addr,
  input  logic [N*WIDTH-1:0]   i_wmem_data,
  output logic [AW-1:0]        o_amem_addr,
  input  logic [N*WIDTH-1:0]   i_amem_data,
  output logic [N*WIDTH-1:0]   o_row_a,
  output logic [N-1:0]         o_row_a_vld,
  output logic [N-1:0]         o_load_col,
  output logic [N*WIDTH-1:0]   o_col_c,
  output logic [N-1:0]         o_col_c_vld,
  input  logic [N*WIDTH-1:0]   i_col_c,
  input  logic [N-1:0]         i_col_c_vld,
  output logic                 o_rmem_we,
  output logic [AW-1:0]        o_rmem_addr,
  output logic [N*WIDTH-1:0]   o_rmem_data
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  state_t                    state, nxt;
  logic [CW-1:0]             m_cnt, k_cnt, in_cnt, out_cnt;
  logic                      w_req, w_dv, a_req, a_dv;
  logic [AW-1:0]             w_idx;
  logic [N-1:0][WIDTH-1:0]   skew_data, algn_data;
  logic [N-1:0]              skew_vld, algn_vld;
  logic                      wr_fire_c;

  assign o_col_c   = '0;
  assign wr_fire_c = (&algn_vld) && (state == STREAM || state == DRAIN);

  // Row r of the activation word gets r extra delay stages.
  for (genvar r = 0; r < N; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign skew_data[r] = i_amem_data[0 +: WIDTH];
      assign skew_vld[r]  = a_dv;
    end else begin : g_dly
      logic [WIDTH-1:0] sd [r];
      logic             sv [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < r; j++) begin
            sd[j] <= '0;
            sv[j] <= 1'b0;
          end
        end else begin
          sd[0] <= i_amem_data[r*WIDTH +: WIDTH];
          sv[0] <= a_dv;
          for (int j = 1; j < r; j++) begin
            sd[j] <= sd[j-1];
            sv[j] <= sv[j-1];
          end
        end
      end
      assign skew_data[r] = sd[r-1];
      assign skew_vld[r]  = sv[r-1];
    end
  end

  // Column c is held N-1-c cycles so every column lines up with the last one.
  for (genvar c = 0; c < N; c++) begin : g_dsk
    if (c == N - 1) begin : g_direct
      assign algn_data[c] = i_col_c[c*WIDTH +: WIDTH];
      assign algn_vld[c]  = i_col_c_vld[c];
    end else begin : g_dly
      localparam int unsigned D = N - 1 - c;
      logic [WIDTH-1:0] dd [D];
      logic             dv [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < int'(D); j++) begin
            dd[j] <= '0;
            dv[j] <= 1'b0;
          end
        end else begin
          dd[0] <= i_col_c[c*WIDTH +: WIDTH];
          dv[0] <= i_col_c_vld[c];
          for (int j = 1; j < int'(D); j++) begin
            dd[j] <= dd[j-1];
            dv[j] <= dv[j-1];
          end
        end
      end
      assign algn_data[c] = dd[D-1];
      assign algn_vld[c]  = dv[D-1];
    end
  end

  // Next state; with M = 0 LOAD lingers until the weight words have been presented.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (i_start) nxt = LOAD;
      LOAD: begin
        if (m_cnt != '0 && k_cnt == CW'(N - 1))      nxt = STREAM;
        else if (m_cnt == '0 && k_cnt == CW'(N + 1)) nxt = DONE;
      end
      STREAM: if (in_cnt == m_cnt) nxt = DRAIN;
      DRAIN:  if (o_rmem_we && out_cnt == m_cnt) nxt = DONE;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      m_cnt       <= '0;
      k_cnt       <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      w_req       <= 1'b0;
      w_dv        <= 1'b0;
      w_idx       <= '0;
      a_req       <= 1'b0;
      a_dv        <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_wmem_addr <= '0;
      o_amem_addr <= '0;
      o_row_a     <= '0;
      o_row_a_vld <= '0;
      o_load_col  <= '0;
      o_col_c_vld <= '0;
      o_rmem_we   <= 1'b0;
      o_rmem_addr <= '0;
      o_rmem_data <= '0;
    end else begin
      state  <= nxt;
      o_busy <= (nxt != IDLE);
      o_done <= (nxt == DONE);
      w_req  <= 1'b0;
      a_req  <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          m_cnt       <= i_m;
          k_cnt       <= '0;
          in_cnt      <= '0;
          out_cnt     <= '0;
          o_wmem_addr <= '0;
          w_req       <= 1'b1;
        end
        LOAD: begin
          k_cnt <= k_cnt + CW'(1);
          if (k_cnt < CW'(N - 1)) begin
            o_wmem_addr <= AW'(k_cnt + CW'(1));
            w_req       <= 1'b1;
          end
          if (nxt == STREAM) begin
            o_amem_addr <= '0;
            in_cnt      <= CW'(1);
            a_req       <= 1'b1;
          end
        end
        STREAM: if (nxt != DRAIN) begin
          o_amem_addr <= in_cnt[AW-1:0];
          in_cnt      <= in_cnt + CW'(1);
          a_req       <= 1'b1;
        end
        default: ;
      endcase

      w_dv  <= w_req;
      w_idx <= o_wmem_addr;
      a_dv  <= a_req;

      // Weight words pass through unskewed; activations only while their row is valid.
      for (int r = 0; r < int'(N); r++) begin
        o_row_a[r*WIDTH +: WIDTH] <= w_dv ? i_wmem_data[r*WIDTH +: WIDTH]
                                          : (skew_vld[r] ? skew_data[r] : '0);
      end
      for (int j = 0; j < int'(N); j++) begin
        o_load_col[j] <= w_dv && (w_idx == AW'(j));
      end
      o_row_a_vld <= skew_vld;
      o_col_c_vld <= skew_vld;

      o_rmem_we <= wr_fire_c;
      if (wr_fire_c) begin
        o_rmem_addr <= out_cnt[AW-1:0];
        o_rmem_data <= algn_data;
        out_cnt     <= out_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sa_ctrl.sv
// Bench for sa_ctrl: behavioural PE array and memories, job vectors with
// hand-computed results, plus abort, busy-restart and skew sequences.
module tb_sa_ctrl;

  localparam int N  = 4;
  localparam int WD = 16;
  localparam int AW = 8;

  logic              clk, rst_n, i_start;
  logic [AW:0]       i_m;
  logic              o_busy, o_done, o_rmem_we;
  logic [AW-1:0]     o_wmem_addr, o_amem_addr, o_rmem_addr;
  logic [N*WD-1:0]   i_wmem_data, i_amem_data, o_row_a, o_col_c, i_col_c, o_rmem_data;
  logic [N-1:0]      o_row_a_vld, o_load_col, o_col_c_vld, i_col_c_vld;

  sa_ctrl #(.N(N), .WIDTH(WD), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_m(i_m),
    .o_busy(o_busy), .o_done(o_done),
    .o_wmem_addr(o_wmem_addr), .i_wmem_data(i_wmem_data),
    .o_amem_addr(o_amem_addr), .i_amem_data(i_amem_data),
    .o_row_a(o_row_a), .o_row_a_vld(o_row_a_vld), .o_load_col(o_load_col),
    .o_col_c(o_col_c), .o_col_c_vld(o_col_c_vld),
    .i_col_c(i_col_c), .i_col_c_vld(i_col_c_vld),
    .o_rmem_we(o_rmem_we), .o_rmem_addr(o_rmem_addr), .o_rmem_data(o_rmem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N*WD-1:0] wmem [256];
  logic [N*WD-1:0] amem [256];

  always @(posedge clk) begin
    i_wmem_data <= wmem[o_wmem_addr];
    i_amem_data <= amem[o_amem_addr];
  end

  // Weight-stationary PE grid: a moves right, partial sums move down.
  logic [WD-1:0] w_m [N][N];
  logic [WD-1:0] a_r [N][N];
  logic [WD-1:0] p_r [N][N];
  logic          av_r [N][N];
  logic          pv_r [N][N];
  logic [WD-1:0] m_ain, m_pin;
  logic          m_avin, m_pvin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_r[r][c] <= '0; p_r[r][c] <= '0; av_r[r][c] <= 1'b0; pv_r[r][c] <= 1'b0;
        end
    end else begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          if (c == 0) begin
            m_ain = o_row_a[r*WD +: WD]; m_avin = o_row_a_vld[r];
          end else begin
            m_ain = a_r[r][c-1]; m_avin = av_r[r][c-1];
          end
          if (r == 0) begin
            m_pin = o_col_c[c*WD +: WD]; m_pvin = o_col_c_vld[c];
          end else begin
            m_pin = p_r[r-1][c]; m_pvin = pv_r[r-1][c];
          end
          a_r[r][c]  <= m_ain;
          av_r[r][c] <= m_avin;
          p_r[r][c]  <= m_pin + m_ain * w_m[r][c];
          pv_r[r][c] <= m_avin & m_pvin;
          if (o_load_col[c]) w_m[r][c] <= o_row_a[r*WD +: WD];
        end
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++) begin
      i_col_c[c*WD +: WD] = p_r[N-1][c];
      i_col_c_vld[c]      = pv_r[N-1][c];
    end
  end

  logic any_out;
  assign any_out = o_busy | o_done | (|o_wmem_addr) | (|o_amem_addr) | (|o_row_a) |
                   (|o_row_a_vld) | (|o_load_col) | (|o_col_c) | (|o_col_c_vld) |
                   o_rmem_we | (|o_rmem_addr) | (|o_rmem_data);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WD-1:0] wval(input int kind, input int r, input int c);
    case (kind)
      0:       return (r == c) ? 16'd1 : 16'd0;
      1:       return 16'(r + c);
      2:       return (r == c) ? 16'd2 : 16'd0;
      default: return 16'd1;
    endcase
  endfunction

  function automatic logic [WD-1:0] aval(input int kind, input int m, input int r);
    case (kind)
      0:       return 16'(4*m + r + 1);
      1:       return 16'(m + 1);
      default: return 16'(m + r);
    endcase
  endfunction

  task automatic fill(input int wk, input int ak);
    for (int k = 0; k < 256; k++)
      for (int r = 0; r < N; r++) begin
        wmem[k][r*WD +: WD] = (k < N) ? wval(wk, r, k) : 16'd0;
        amem[k][r*WD +: WD] = aval(ak, k, r);
      end
  endtask

  logic [N-1:0]    lc_log [256];
  logic [N*WD-1:0] ra_log [256];
  logic [N-1:0]    vld_log [256];
  logic [N-1:0]    cv_log [256];
  int done_k, done_cnt, busy_cnt, wr_cnt, first_wr, last_wr, addr_err, vld_cnt;
  logic [63:0] c0_got, cl_got;
  logic busy_after;

  // Start a job at the next edge and log outputs by cycle offset k from S.
  task automatic run_job(input int m, input int poke);
    done_k = -1; done_cnt = 0; busy_cnt = 0; wr_cnt = 0; first_wr = 0; last_wr = 0;
    addr_err = 0; vld_cnt = 0; c0_got = '0; cl_got = '0; busy_after = 1'b1;
    @(negedge clk);
    i_start = 1'b1;
    i_m     = 9'(m);
    for (int k = 1; k < 200; k++) begin
      @(posedge clk); #1;
      i_start = (poke != 0) && (k == 8 || k == 9);
      lc_log[k] = o_load_col; ra_log[k] = o_row_a;
      vld_log[k] = o_row_a_vld; cv_log[k] = o_col_c_vld;
      vld_cnt += $countones(o_row_a_vld);
      if (o_busy) busy_cnt++;
      if (done_k >= 0 && k == done_k + 1) busy_after = o_busy;
      if (o_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (o_rmem_we) begin
        if (o_rmem_addr != 8'(wr_cnt)) addr_err++;
        if (wr_cnt == 0) begin first_wr = k; c0_got = o_rmem_data; end
        last_wr = k; cl_got = o_rmem_data;
        wr_cnt++;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    i_start = 1'b0;
  endtask

  typedef struct {
    int m; int wk; int ak; int poke; int done_at; int first_wr;
    logic [63:0] c0; logic [63:0] cl;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    int dcnt, wcnt;
    vecs[0] = '{1,  0, 0, 0, 16, 15, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001};
    vecs[1] = '{3,  1, 1, 0, 18, 15, 64'h0012_000E_000A_0006, 64'h0036_002A_001E_0012};
    vecs[2] = '{0,  1, 1, 0,  7,  0, 64'h0,                   64'h0};
    vecs[3] = '{8,  2, 0, 1, 23, 15, 64'h0008_0006_0004_0002, 64'h0040_003E_003C_003A};
    vecs[4] = '{20, 3, 2, 0, 35, 15, 64'h0006_0006_0006_0006, 64'h0052_0052_0052_0052};

    rst_n = 1'b0; i_start = 1'b0; i_m = '0;
    fill(0, 0);
    repeat (3) @(posedge clk);
    #1 chk("reset_state", 64'(any_out), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Abort mid-STREAM: outputs clear at once, nothing more is written or signalled.
    fill(2, 0);
    @(negedge clk);
    i_start = 1'b1; i_m = 9'd8;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    chk("abort_busy_before", 64'(o_busy), 64'd1);
    #3 rst_n = 1'b0;
    #1 chk("abort_outs_zero", 64'(any_out), 64'd0);
    dcnt = 0; wcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done) dcnt++;
      if (o_rmem_we) wcnt++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (o_done) dcnt++;
      if (o_rmem_we) wcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    chk("abort_no_write", 64'(wcnt), 64'd0);

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].wk, vecs[v].ak);
      run_job(vecs[v].m, vecs[v].poke);
      chk($sformatf("v%0d_done_at", v),   64'(done_k),   64'(vecs[v].done_at));
      chk($sformatf("v%0d_done_cnt", v),  64'(done_cnt), 64'd1);
      chk($sformatf("v%0d_busy_cyc", v),  64'(busy_cnt), 64'(vecs[v].done_at));
      chk($sformatf("v%0d_busy_off", v),  64'(busy_after), 64'd0);
      chk($sformatf("v%0d_wr_cnt", v),    64'(wr_cnt),   64'(vecs[v].m));
      chk($sformatf("v%0d_vld_cnt", v),   64'(vld_cnt),  64'(vecs[v].m * N));
      for (int j = 0; j < N; j++) begin
        chk($sformatf("v%0d_load_col%0d", v, j), 64'(lc_log[3+j]), 64'(4'b0001 << j));
        chk($sformatf("v%0d_load_w%0d", v, j),   ra_log[3+j],       wmem[j]);
      end
      chk($sformatf("v%0d_load_col_edges", v), 64'(lc_log[2] | lc_log[7]), 64'd0);
      chk($sformatf("v%0d_no_vld_in_load", v),
          64'(vld_log[1] | vld_log[2] | vld_log[3] | vld_log[4] | vld_log[5] | vld_log[6]), 64'd0);
      if (vecs[v].m > 0) begin
        chk($sformatf("v%0d_first_wr", v), 64'(first_wr), 64'(vecs[v].first_wr));
        chk($sformatf("v%0d_last_wr", v),  64'(last_wr),  64'(vecs[v].first_wr + vecs[v].m - 1));
        chk($sformatf("v%0d_addr_seq", v), 64'(addr_err), 64'd0);
        chk($sformatf("v%0d_c_first", v),  c0_got, vecs[v].c0);
        chk($sformatf("v%0d_c_last", v),   cl_got, vecs[v].cl);
      end
      if (vecs[v].m == 1) begin
        for (int r = 0; r < N; r++) begin
          chk($sformatf("skew_row%0d_rise", r), 64'({vld_log[6+r][r], vld_log[7+r][r]}), 64'b01);
          chk($sformatf("skew_col%0d_rise", r), 64'({cv_log[6+r][r], cv_log[7+r][r]}), 64'b01);
        end
      end
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
